// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM state encoding, access-size type and
// the byte-swap helper shared by the load/store unit files.
// Build option: define LSU_MISALIGN_CHECK_EN to reject misaligned/illegal requests.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package load_store_unit_pkg;

  localparam int unsigned WORD_SIZE = `WORD_SIZE;

  // RV32I load/store funct3 codes
  localparam logic [2:0] LSU_B  = 3'd0;
  localparam logic [2:0] LSU_H  = 3'd1;
  localparam logic [2:0] LSU_W  = 3'd2;
  localparam logic [2:0] LSU_BU = 3'd4;
  localparam logic [2:0] LSU_HU = 3'd5;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Memory read word is big-endian (byte addr+0 in [31:24]); flip to little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] i_word);
    return {i_word[7:0], i_word[15:8], i_word[23:16], i_word[31:24]};
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// load_store_unit_lane: combinational datapath of the load/store unit.
// Byte-swaps the memory read word, extracts and extends load lanes, and merges
// sub-word store data into the old word for read-modify-write.
module load_store_unit_lane
  import load_store_unit_pkg::*;
(
  input  logic [WORD_SIZE-1:0] i_mem_rd,
  input  logic [1:0]           i_lane,
  input  lsu_size_e            i_size,
  input  logic                 i_unsigned,
  input  logic [WORD_SIZE-1:0] i_wdata,
  output logic [WORD_SIZE-1:0] o_load_data,
  output logic [WORD_SIZE-1:0] o_merged
);

  logic [31:0] w_le;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_le   = byte_swap(i_mem_rd);
  assign w_half = i_lane[1] ? w_le[31:16] : w_le[15:0];

  // Select the addressed byte lane of the little-endian word
  always_comb begin
    w_byte = w_le[7:0];
    case (i_lane)
      2'd0:    w_byte = w_le[7:0];
      2'd1:    w_byte = w_le[15:8];
      2'd2:    w_byte = w_le[23:16];
      2'd3:    w_byte = w_le[31:24];
      default: w_byte = w_le[7:0];
    endcase
  end

  // Sign- or zero-extend the selected lane to a full load result
  always_comb begin
    o_load_data = w_le;
    case (i_size)
      SZ_B:    o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_W:    o_load_data = w_le;
      default: o_load_data = w_le;
    endcase
  end

  // Overlay the store lane onto the old word; full-word stores replace it
  always_comb begin
    o_merged = w_le;
    case (i_size)
      SZ_B: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_lane[1]) begin
          o_merged[31:16] = i_wdata[15:0];
        end else begin
          o_merged[15:0] = i_wdata[15:0];
        end
      end
      SZ_W:    o_merged = i_wdata;
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for the byte-addressed data memory.
// Accepts one request at a time, sequences read / write cycles (sub-word stores
// become read-modify-write) and returns a one-cycle response.
// Build option: LSU_MISALIGN_CHECK_EN -- when defined, misaligned or illegal
// requests are answered with o_rsp_err and no memory access; otherwise the
// address is naturally aligned and illegal funct3 behaves as a word access.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_we,
  input  logic [2:0]           i_req_funct3,
  input  logic [WORD_SIZE-1:0] i_req_addr,
  input  logic [WORD_SIZE-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  output logic [WORD_SIZE-1:0] o_rsp_rdata,
  output logic                 o_rsp_err,
  output logic [WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0] o_mem_wd,
  output logic                 o_mem_wen,
  output logic                 o_mem_ren,
  input  logic [WORD_SIZE-1:0] i_mem_rd
);

  logic [1:0]  r_state;
  logic        r_we;
  lsu_size_e   r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_data;   // load result, merged word or SW data

  lsu_size_e   w_size_raw;
  lsu_size_e   w_size;
  logic        w_uns;
  logic        w_legal;
  logic        w_misalign;
  logic [31:0] w_addr_aligned;
  logic [31:0] w_addr;
  logic        w_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Decode funct3 into access size / signedness and flag illegal encodings
  always_comb begin
    w_size_raw = SZ_W;
    w_uns      = 1'b0;
    w_legal    = 1'b1;
    case (i_req_funct3)
      LSU_B:   w_size_raw = SZ_B;
      LSU_H:   w_size_raw = SZ_H;
      LSU_W:   w_size_raw = SZ_W;
      LSU_BU: begin
        w_size_raw = SZ_B;
        w_uns      = ~i_req_we;
        w_legal    = ~i_req_we;
      end
      LSU_HU: begin
        w_size_raw = SZ_H;
        w_uns      = ~i_req_we;
        w_legal    = ~i_req_we;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_size = w_legal ? w_size_raw : SZ_W;

  // Detect misalignment and compute the naturally aligned address
  always_comb begin
    w_misalign     = 1'b0;
    w_addr_aligned = i_req_addr;
    case (w_size)
      SZ_B: begin
        w_misalign     = 1'b0;
        w_addr_aligned = i_req_addr;
      end
      SZ_H: begin
        w_misalign     = i_req_addr[0];
        w_addr_aligned = {i_req_addr[31:1], 1'b0};
      end
      SZ_W: begin
        w_misalign     = |i_req_addr[1:0];
        w_addr_aligned = {i_req_addr[31:2], 2'b00};
      end
      default: begin
        w_misalign     = |i_req_addr[1:0];
        w_addr_aligned = {i_req_addr[31:2], 2'b00};
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_err  = ~w_legal | w_misalign;
  assign w_addr = i_req_addr;
`else
  assign w_err  = 1'b0;
  assign w_addr = w_misalign ? w_addr_aligned : i_req_addr;
`endif

  load_store_unit_lane u_lane (
    .i_mem_rd    (i_mem_rd),
    .i_lane      (r_addr[1:0]),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // Request registers and IDLE -> READ/WRITE -> RESP sequencing
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_data     <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_size     <= w_size;
            r_unsigned <= w_uns;
            r_addr     <= w_addr;
            r_wdata    <= i_req_wdata;
            r_err      <= w_err;
            if (w_err) begin
              r_data  <= 32'h0000_0000;
              r_state <= ST_RESP;
            end else if (i_req_we && (w_size == SZ_W)) begin
              r_data  <= i_req_wdata;
              r_state <= ST_WRITE;
            end else begin
              r_data  <= 32'h0000_0000;
              r_state <= ST_READ;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_data  <= w_merged;
            r_state <= ST_WRITE;
          end else begin
            r_data  <= w_load_data;
            r_state <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_data  <= 32'h0000_0000;   // stores respond with zero data
          r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decode state into handshake / memory strobes, all forced low during reset
  always_comb begin
    o_req_ready = 1'b0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wd    = 32'h0000_0000;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_rsp_rdata = 32'h0000_0000;
    o_mem_addr  = 32'h0000_0000;
    if (!i_rst) begin
      o_mem_addr = {r_addr[31:2], 2'b00};
      case (r_state)
        ST_IDLE:  o_req_ready = 1'b1;
        ST_READ:  o_mem_ren   = 1'b1;
        ST_WRITE: begin
          o_mem_wen = 1'b1;
          o_mem_wd  = r_data;
        end
        ST_RESP: begin
          o_rsp_valid = 1'b1;
          o_rsp_err   = r_err;
          o_rsp_rdata = r_data;
        end
        default: o_req_ready = 1'b0;
      endcase
    end else begin
      o_mem_addr = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. A byte-array
// reference memory plus per-request latency rules predict every output each
// cycle; a negedge compare process checks them, and literal pins anchor the
// reference against hand-computed values.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wd;
  logic        o_mem_wen;
  logic        o_mem_ren;
  logic [31:0] i_mem_rd;

  load_store_unit dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wd     (o_mem_wd),
    .o_mem_wen    (o_mem_wen),
    .o_mem_ren    (o_mem_ren),
    .i_mem_rd     (i_mem_rd)
  );

  always #5 i_clk = ~i_clk;

  // Environment memory seen by the DUT
  logic [7:0] env_mem [0:255];
  logic [7:0] w_a;
  assign w_a      = o_mem_addr[7:0];
  assign i_mem_rd = {env_mem[w_a], env_mem[w_a + 8'd1], env_mem[w_a + 8'd2], env_mem[w_a + 8'd3]};

  always @(posedge i_clk) begin
    if (o_mem_wen) begin
      for (int k = 0; k < 4; k++) env_mem[w_a + 8'(k)] <= o_mem_wd[8*k +: 8];
    end
  end

  // Reference memory used by the model
  logic [7:0] ref_mem [0:255];

  int n_checks = 0;
  int n_err    = 0;

  logic        chk_en = 1'b0;
  logic        exp_rst, exp_ready, exp_ren, exp_wen, exp_valid, exp_err;
  logic [31:0] exp_wd, exp_rdata, exp_addr;
  logic [31:0] last_rdata, last_wd;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("ready", {31'd0, o_req_ready}, {31'd0, exp_ready});
      check("ren",   {31'd0, o_mem_ren},   {31'd0, exp_ren});
      check("wen",   {31'd0, o_mem_wen},   {31'd0, exp_wen});
      check("rsp_valid", {31'd0, o_rsp_valid}, {31'd0, exp_valid});
      check("mem_wd", o_mem_wd, exp_wd);
      if (exp_valid || exp_rst) begin
        check("rsp_err",   {31'd0, o_rsp_err}, {31'd0, exp_err});
        check("rsp_rdata", o_rsp_rdata, exp_rdata);
      end
      if (exp_ren || exp_wen || exp_rst) check("mem_addr", o_mem_addr, exp_addr);
      if (o_rsp_valid) begin
        last_rdata = o_rsp_rdata;
        last_err   = o_rsp_err;
      end
      if (o_mem_wen) last_wd = o_mem_wd;
    end
  end

  task automatic set_exp_idle();
    exp_rst = 1'b0; exp_ready = 1'b1; exp_ren = 1'b0; exp_wen = 1'b0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_wd = 32'd0; exp_rdata = 32'd0; exp_addr = 32'd0;
  endtask

  task automatic set_exp_rst();
    exp_rst = 1'b1; exp_ready = 1'b0; exp_ren = 1'b0; exp_wen = 1'b0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_wd = 32'd0; exp_rdata = 32'd0; exp_addr = 32'd0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    env_mem[16] = 8'h11; env_mem[17] = 8'h22; env_mem[18] = 8'h83; env_mem[19] = 8'h44;
    ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h83; ref_mem[19] = 8'h44;
  endtask

  // Issue one request and predict every cycle until it completes.
  // rst_at > 0 asserts reset in that cycle after accept, aborting the request.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rst_at);
    int          nb, lat, wcyc, base, off;
    int unsigned a, ea;
    logic        legal, sgn, err, need_rd, aborted;
    logic [31:0] val, wd, rdata;

    a = addr; legal = 1'b1; sgn = 1'b1;
    case (f3)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd2: nb = 4;
      3'd4: begin nb = 1; sgn = 1'b0; legal = !we; end
      3'd5: begin nb = 2; sgn = 1'b0; legal = !we; end
      default: begin nb = 4; legal = 1'b0; end
    endcase
    if (!legal) begin nb = 4; sgn = 1'b1; end
`ifdef LSU_MISALIGN_CHECK_EN
    err = !legal || ((a % nb) != 0);
    ea  = a;
`else
    err = 1'b0;
    ea  = a - (a % nb);
`endif
    base = int'(ea) & ~3;
    off  = int'(ea) & 3;
    val = 32'd0;
    for (int i = 0; i < nb; i++) val |= 32'(ref_mem[(int'(ea) + i) & 255]) << (8*i);
    if (sgn && nb < 4 && val[8*nb-1]) val |= ~((32'd1 << (8*nb)) - 32'd1);
    wd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    for (int i = 0; i < nb; i++) wd[8*(off+i) +: 8] = wdata[8*i +: 8];
    rdata   = (we || err) ? 32'd0 : val;
    lat     = err ? 1 : ((!we || nb == 4) ? 2 : 3);
    need_rd = !err && (!we || nb < 4);
    wcyc    = (!err && we) ? ((nb == 4) ? 1 : 2) : 0;

    last_rdata = 32'hDEAD_0001; last_wd = 32'hDEAD_0002; last_err = 1'bx;
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wdata;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k == rst_at) begin
        i_rst = 1'b1; set_exp_rst(); aborted = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        break;
      end
      exp_rst = 1'b0; exp_ready = 1'b0;
      exp_ren   = need_rd && (k == 1);
      exp_wen   = (k == wcyc);
      exp_wd    = exp_wen ? wd : 32'd0;
      exp_valid = (k == lat);
      exp_err   = (k == lat) && err;
      exp_rdata = rdata;
      exp_addr  = 32'(base);
      @(posedge i_clk); #1;
    end
    set_exp_idle();
    if (!aborted && we && !err) begin
      for (int i = 0; i < 4; i++) ref_mem[base+i] = wd[8*i +: 8];
    end
  endtask

  initial begin
    i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'd0;
    i_req_addr = 32'd0; i_req_wdata = 32'd0;
    preload();
    set_exp_rst();
    #1 chk_en = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    set_exp_idle();
    @(posedge i_clk); #1;

    // 1. word load
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("pin LW 0x10", last_rdata, 32'h4483_2211);
    // 2. sub-word loads with extension
    run_req(1'b0, 3'd0, 32'h12, 32'h0, 0);
    check("pin LB 0x12", last_rdata, 32'hFFFF_FF83);
    run_req(1'b0, 3'd4, 32'h12, 32'h0, 0);
    check("pin LBU 0x12", last_rdata, 32'h0000_0083);
    run_req(1'b0, 3'd1, 32'h12, 32'h0, 0);
    check("pin LH 0x12", last_rdata, 32'h0000_4483);
    run_req(1'b0, 3'd1, 32'h10, 32'h0, 0);
    check("pin LH 0x10", last_rdata, 32'h0000_2211);
    run_req(1'b0, 3'd5, 32'h12, 32'h0, 0);
    check("pin LHU 0x12", last_rdata, 32'h0000_4483);
    // 3. byte store (read-modify-write)
    preload();
    run_req(1'b1, 3'd0, 32'h11, 32'h0000_00AB, 0);
    check("pin SB wd", last_wd, 32'h4483_AB11);
    check("pin SB rdata", last_rdata, 32'h0);
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("pin LW after SB", last_rdata, 32'h4483_AB11);
    // 4. halfword and word stores
    preload();
    run_req(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 0);
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("pin LW after SH", last_rdata, 32'hBEEF_2211);
    run_req(1'b1, 3'd2, 32'h10, 32'hCAFE_F00D, 0);
    check("pin SW wd", last_wd, 32'hCAFE_F00D);
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("pin LW after SW", last_rdata, 32'hCAFE_F00D);
    // 5. misaligned and illegal requests
    preload();
    run_req(1'b0, 3'd2, 32'h11, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("pin LW 0x11 err", {31'd0, last_err}, 32'd1);
    check("pin LW 0x11 rdata", last_rdata, 32'h0);
`else
    check("pin LW 0x11 err", {31'd0, last_err}, 32'd0);
    check("pin LW 0x11 rdata", last_rdata, 32'h4483_2211);
`endif
    run_req(1'b0, 3'd3, 32'h10, 32'h0, 0);
    run_req(1'b0, 3'd1, 32'h13, 32'h0, 0);
    run_req(1'b1, 3'd4, 32'h10, 32'h1234_5678, 0);
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    // 6. reset during the WRITE cycle of a halfword store
    preload();
    run_req(1'b1, 3'd1, 32'h12, 32'h0000_BEEF, 2);
    run_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("pin LW after abort", last_rdata, 32'h4483_2211);

    repeat (2) @(posedge i_clk);
    #1 chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
